// File: rtl/timestamp_pkg.sv
// timestamp_pkg: event word layout and time field widths shared with the NMEA timestamp stage
package timestamp_pkg;
    localparam int EVT_W      = 64;
    localparam int SEQ_W      = 8;
    localparam int HR_W       = 5;
    localparam int MIN_W      = 6;
    localparam int SEC_W      = 6;
    localparam int SUBSEC_W   = 32;
    localparam int SEQ_LSB    = 56;
    localparam int HR_LSB     = 48;
    localparam int MIN_LSB    = 40;
    localparam int SEC_LSB    = 32;
    localparam int SUBSEC_LSB = 0;

    function automatic logic [EVT_W-1:0] pack_evt(
        input logic [SEQ_W-1:0]    seq,
        input logic [HR_W-1:0]     hr,
        input logic [MIN_W-1:0]    min,
        input logic [SEC_W-1:0]    sec,
        input logic [SUBSEC_W-1:0] subsec
    );
        logic [EVT_W-1:0] w;
        w = '0;
        w[SEQ_LSB +: SEQ_W]       = seq;
        w[HR_LSB +: HR_W]         = hr;
        w[MIN_LSB +: MIN_W]       = min;
        w[SEC_LSB +: SEC_W]       = sec;
        w[SUBSEC_LSB +: SUBSEC_W] = subsec;
        return w;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered head word
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    // dout always mirrors mem[rd_ptr]; a push into an empty (or emptying) queue loads it directly
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (do_push && (empty || (do_pop && count == (AW+1)'(1))))
                dout <= din;
            else if (do_pop)
                dout <= mem[rd_ptr + 1'b1];
        end
    end
endmodule

// File: rtl/timestamp_event_capture.sv
// timestamp_event_capture: timestamps synchronised trigger edges and queues them as 64-bit words
module timestamp_event_capture
    import timestamp_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int SYNC_LEN   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_trig,
    input  logic [HR_W-1:0]             hr,
    input  logic [MIN_W-1:0]            min,
    input  logic [SEC_W-1:0]            sec,
    input  logic [SUBSEC_W-1:0]         subsec,
    input  logic                        bcd_valid,
    output logic [EVT_W-1:0]            m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]            overflow_cnt,
    output logic [CNT_W-1:0]            unsynced_cnt
);
    logic [SYNC_LEN-1:0] sync, settle;
    logic                dly, armed, evt, push, pop, full, empty;
    logic [SEQ_W-1:0]    seq;

    assign evt      = sync[SYNC_LEN-1] & ~dly & armed;
    assign push     = evt & bcd_valid;
    assign pop      = m_tvalid & m_tready;
    assign m_tvalid = ~empty;

    // settle tracks when the chain holds real post-reset samples; a trigger held
    // high through reset must be seen low before any edge can count
    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= '0;
            settle       <= '0;
            dly          <= 1'b0;
            armed        <= 1'b0;
            seq          <= '0;
            overflow_cnt <= '0;
            unsynced_cnt <= '0;
        end else begin
            sync   <= {sync[SYNC_LEN-2:0], i_trig};
            settle <= {settle[SYNC_LEN-2:0], 1'b1};
            dly    <= sync[SYNC_LEN-1];
            armed  <= armed | (settle[SYNC_LEN-1] & ~sync[SYNC_LEN-1]);
            if (evt) seq <= seq + 1'b1;
            if (evt && !bcd_valid && !(&unsynced_cnt))
                unsynced_cnt <= unsynced_cnt + CNT_W'(1);
            if (push && full && !pop && !(&overflow_cnt))
                overflow_cnt <= overflow_cnt + CNT_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH(EVT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (pack_evt(seq, hr, min, sec, subsec)),
        .pop  (pop),
        .dout (m_tdata),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_timestamp_event_capture.sv
// tb_timestamp_event_capture: scoreboard bench driving a bench-owned time source and trigger pulses
module tb_timestamp_event_capture;
    localparam int DEPTH = 16;
    localparam int SYNC  = 3;
    localparam int PPS   = 5000;

    logic        clk = 1'b0;
    logic        rst, i_trig, bcd_valid, m_tready, m_tvalid;
    logic [4:0]  hr;
    logic [5:0]  min, sec;
    logic [31:0] subsec;
    logic [63:0] m_tdata;
    logic [4:0]  fifo_count;
    logic [15:0] overflow_cnt, unsynced_cnt;

    int          checks = 0, failures = 0;
    int          cyc, mcount, m_over, m_unsync, pops;
    logic [7:0]  mseq;
    logic [63:0] last_word;
    logic [63:0] exp_q[$];
    int          evt_q[$];
    logic [31:0] s0;

    timestamp_event_capture #(.FIFO_DEPTH(DEPTH), .SYNC_LEN(SYNC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_trig(i_trig), .hr(hr), .min(min), .sec(sec), .subsec(subsec),
        .bcd_valid(bcd_valid), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fifo_count(fifo_count), .overflow_cnt(overflow_cnt), .unsynced_cnt(unsynced_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare this cycle's outputs, run the model for this cycle's inputs, then advance one clock
    task automatic step();
        logic p, pu;
        logic [63:0] e;
        chk("tvalid", 64'(m_tvalid), 64'(mcount != 0));
        chk("count", 64'(fifo_count), 64'(mcount));
        chk("ovf", 64'(overflow_cnt), 64'(m_over));
        chk("unsync", 64'(unsynced_cnt), 64'(m_unsync));
        p  = (mcount != 0) && m_tready;
        pu = 1'b0;
        if (p) begin
            e = exp_q.pop_front();
            chk("data", m_tdata, e);
            last_word = m_tdata;
            pops++;
        end
        if (evt_q.size() != 0 && evt_q[0] == cyc) begin
            void'(evt_q.pop_front());
            if (!bcd_valid) m_unsync++;
            else if (mcount < DEPTH || p) begin
                exp_q.push_back({mseq, 3'b0, hr, 2'b0, min, 2'b0, sec, subsec});
                pu = 1'b1;
            end else m_over++;
            mseq++;
        end
        mcount = mcount + int'(pu) - int'(p);
        @(posedge clk);
        #1;
        cyc++;
        if (subsec == 32'(PPS - 1)) begin
            subsec = 0;
            if (sec == 6'd59) begin
                sec = 6'd0;
                min = (min == 6'd59) ? 6'd0 : min + 6'd1;
            end else sec = sec + 6'd1;
        end else subsec = subsec + 32'd1;
    endtask

    task automatic pulse();
        i_trig = 1'b1;
        evt_q.push_back(cyc + SYNC);
        step();
        step();
        i_trig = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        exp_q.delete();
        evt_q.delete();
        mcount = 0; mseq = 0; m_over = 0; m_unsync = 0;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(overflow_cnt), 64'd0);
        chk("rst_unsync", 64'(unsynced_cnt), 64'd0);
        repeat (6) step();
    endtask

    initial begin
        rst = 1'b1; i_trig = 1'b0; bcd_valid = 1'b1; m_tready = 1'b1;
        hr = 5'd12; min = 6'd34; sec = 6'd56; subsec = 32'd1000;
        cyc = 0; pops = 0; last_word = '0;
        mcount = 0; mseq = 0; m_over = 0; m_unsync = 0;
        do_reset();

        // single event, field layout and sampling latency
        subsec = 32'd1000;
        s0 = subsec;
        pops = 0;
        pulse();
        repeat (6) step();
        chk("t1_pops", 64'(pops), 64'd1);
        chk("t1_seq", 64'(last_word[63:56]), 64'd0);
        chk("t1_hr", 64'(last_word[52:48]), 64'd12);
        chk("t1_min", 64'(last_word[45:40]), 64'd34);
        chk("t1_sec", 64'(last_word[37:32]), 64'd56);
        chk("t1_subsec", 64'(last_word[31:0]), 64'(s0 + 32'(SYNC)));

        // events while unsynchronised are counted, not queued, but consume seq
        do_reset();
        pops = 0;
        bcd_valid = 1'b0;
        repeat (3) pulse();
        repeat (4) step();
        chk("t2_unsync", 64'(unsynced_cnt), 64'd3);
        chk("t2_nopops", 64'(pops), 64'd0);
        bcd_valid = 1'b1;
        pulse();
        repeat (6) step();
        chk("t2_pops", 64'(pops), 64'd1);
        chk("t2_seq", 64'(last_word[63:56]), 64'd3);

        // overflow with a stalled sink, then in-order drain
        do_reset();
        m_tready = 1'b0;
        repeat (18) begin
            pulse();
            repeat (6) step();
        end
        chk("t3_count", 64'(fifo_count), 64'd16);
        chk("t3_ovf", 64'(overflow_cnt), 64'd2);
        m_tready = 1'b1;
        pops = 0;
        repeat (20) step();
        chk("t3_pops", 64'(pops), 64'd16);
        chk("t3_lastseq", 64'(last_word[63:56]), 64'd15);

        // full FIFO with a pop in the event cycle accepts the write
        m_tready = 1'b0;
        repeat (16) begin
            pulse();
            repeat (2) step();
        end
        chk("t4_full", 64'(fifo_count), 64'd16);
        i_trig = 1'b1;
        evt_q.push_back(cyc + SYNC);
        step();
        step();
        i_trig = 1'b0;
        step();
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        step();
        chk("t4_count", 64'(fifo_count), 64'd16);
        chk("t4_ovf", 64'(overflow_cnt), 64'd2);
        m_tready = 1'b1;
        repeat (20) step();

        // event on the PPS cycle keeps the old second and pre-reset subsec
        sec = 6'd59;
        subsec = 32'(PPS - 1 - SYNC);
        pulse();
        repeat (4) step();
        chk("t5_sec", 64'(last_word[37:32]), 64'd59);
        chk("t5_sub", 64'(last_word[31:0]), 64'(PPS - 1));
        pulse();
        repeat (4) step();
        chk("t5_sec2", 64'(last_word[37:32]), 64'd0);
        chk("t5_sub2", 64'(last_word[31:0]), 64'd7);

        // reset mid-operation with the trigger held high
        m_tready = 1'b0;
        bcd_valid = 1'b0;
        pulse();
        bcd_valid = 1'b1;
        repeat (5) pulse();
        repeat (4) step();
        chk("t6_pre_count", 64'(fifo_count), 64'd5);
        chk("t6_pre_unsync", 64'(unsynced_cnt), 64'd1);
        i_trig = 1'b1;
        do_reset();
        repeat (20) step();
        chk("t6_noevt", 64'(fifo_count), 64'd0);
        i_trig = 1'b0;
        repeat (4) step();
        m_tready = 1'b1;
        pops = 0;
        pulse();
        repeat (6) step();
        chk("t6_pops", 64'(pops), 64'd1);
        chk("t6_seq", 64'(last_word[63:56]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
